// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Operand-bypass select generation and load-use stall sequencing for the
//   in-order pipeline.
//
//   Ports
//     clk, arst_n          clock (rising edge), async active-low reset
//     IF_ID_Rs             decode-stage source addresses (packed per src)
//     ID_EX_Rs             EX-stage source addresses (packed per src)
//     ID_EX_Rd/MemRead     EX-stage destination / load flag
//     EX_MEM_Rd/RegWrite/MemRead   MEM-stage destination and controls
//     MEM_WB_Rd/RegWrite   WB-stage destination and write enable
//     flush                redirect, kills the IF/ID instruction
//     stat_clr             synchronous clear of stall_count
//     fwd_sel              per-src bypass select: 00 RF, 01 EX/MEM, 10 MEM/WB
//     stall_if/stall_id/bubble_ex   stall controls (always equal)
//     stall_count          saturating count of stalled cycles
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no stall in progress; a load-use hazard stalls this cycle
//   ST_STALL | remaining cycles of a multi-cycle load-use stall (r_cnt left)

module fwd_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_LAT    = 1,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [NUM_SRC*REG_AW-1:0] IF_ID_Rs,
    input  logic [NUM_SRC*REG_AW-1:0] ID_EX_Rs,
    input  logic [REG_AW-1:0]         ID_EX_Rd,
    input  logic                      ID_EX_MemRead,
    input  logic [REG_AW-1:0]         EX_MEM_Rd,
    input  logic                      EX_MEM_RegWrite,
    input  logic                      EX_MEM_MemRead,
    input  logic [REG_AW-1:0]         MEM_WB_Rd,
    input  logic                      MEM_WB_RegWrite,
    input  logic                      flush,
    input  logic                      stat_clr,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      bubble_ex,
    output logic [15:0]               stall_count
);

    if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
        $fatal(1, "fwd_hazard_ctrl: LOAD_LAT must be in 1..15");
    end
    if (NUM_SRC < 1 || NUM_SRC > 4) begin : g_bad_num_src
        $fatal(1, "fwd_hazard_ctrl: NUM_SRC must be in 1..4");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [15:0]         r_stall_count;
    logic [2*NUM_SRC-1:0] w_fwd_sel;
    logic                w_hazard;
    logic                w_stall;

    // Register 0 never participates when it is hardwired to zero.
    function automatic logic nz(input logic [REG_AW-1:0] r);
        return (ZERO_REG_EN == 0) || (r != '0);
    endfunction

    // A load in MEM has no data yet, so it is excluded from the EX/MEM path;
    // its result arrives one cycle later through MEM/WB.
    always_comb begin
        w_fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!arst_n) begin
                w_fwd_sel[2*i +: 2] = 2'b00;
            end else if (EX_MEM_RegWrite && !EX_MEM_MemRead && nz(EX_MEM_Rd) &&
                         (EX_MEM_Rd == ID_EX_Rs[i*REG_AW +: REG_AW])) begin
                w_fwd_sel[2*i +: 2] = 2'b01;
            end else if (MEM_WB_RegWrite && nz(MEM_WB_Rd) &&
                         (MEM_WB_Rd == ID_EX_Rs[i*REG_AW +: REG_AW])) begin
                w_fwd_sel[2*i +: 2] = 2'b10;
            end else begin
                w_fwd_sel[2*i +: 2] = 2'b00;
            end
        end
    end

    always_comb begin
        w_hazard = 1'b0;
        if (ID_EX_MemRead && nz(ID_EX_Rd)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (ID_EX_Rd == IF_ID_Rs[i*REG_AW +: REG_AW]) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    // Mealy stall: the first stall cycle is raised in IDLE directly from the
    // hazard. A flush drops the stall in the same cycle since the killed
    // instruction needs no hold. Forced low while reset is asserted.
    always_comb begin
        w_stall = 1'b0;
        if (arst_n && !flush) begin
            w_stall = (r_state == ST_STALL) || w_hazard;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hazard && !flush && (LOAD_LAT > 1)) begin
                        r_state <= ST_STALL;
                        r_cnt   <= 4'(LOAD_LAT - 1);
                    end
                end
                ST_STALL: begin
                    if (flush || (r_cnt == 4'd1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_count <= 16'd0;
        end else if (stat_clr) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign fwd_sel     = w_fwd_sel;
    assign stall_if    = w_stall;
    assign stall_id    = w_stall;
    assign bubble_ex   = w_stall;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl. Three instances share the stimulus:
//   a: LOAD_LAT=3, zero register enabled
//   b: LOAD_LAT=4, zero register enabled
//   c: LOAD_LAT=1, zero register disabled

module tb_fwd_hazard_ctrl;

    localparam int AW = 5;
    localparam int NS = 2;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [NS*AW-1:0] IF_ID_Rs;
    logic [NS*AW-1:0] ID_EX_Rs;
    logic [AW-1:0]   ID_EX_Rd;
    logic            ID_EX_MemRead;
    logic [AW-1:0]   EX_MEM_Rd;
    logic            EX_MEM_RegWrite;
    logic            EX_MEM_MemRead;
    logic [AW-1:0]   MEM_WB_Rd;
    logic            MEM_WB_RegWrite;
    logic            flush;
    logic            stat_clr;

    logic [2*NS-1:0] fwd_a, fwd_b, fwd_c;
    logic            sif_a, sid_a, bub_a;
    logic            sif_b, sid_b, bub_b;
    logic            sif_c, sid_c, bub_c;
    logic [15:0]     cnt_a, cnt_b, cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3), .ZERO_REG_EN(1)) u_dut_a (
        .clk(clk), .arst_n(arst_n), .IF_ID_Rs(IF_ID_Rs), .ID_EX_Rs(ID_EX_Rs),
        .ID_EX_Rd(ID_EX_Rd), .ID_EX_MemRead(ID_EX_MemRead), .EX_MEM_Rd(EX_MEM_Rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
        .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite), .flush(flush),
        .stat_clr(stat_clr), .fwd_sel(fwd_a), .stall_if(sif_a), .stall_id(sid_a),
        .bubble_ex(bub_a), .stall_count(cnt_a));

    fwd_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(4), .ZERO_REG_EN(1)) u_dut_b (
        .clk(clk), .arst_n(arst_n), .IF_ID_Rs(IF_ID_Rs), .ID_EX_Rs(ID_EX_Rs),
        .ID_EX_Rd(ID_EX_Rd), .ID_EX_MemRead(ID_EX_MemRead), .EX_MEM_Rd(EX_MEM_Rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
        .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite), .flush(flush),
        .stat_clr(stat_clr), .fwd_sel(fwd_b), .stall_if(sif_b), .stall_id(sid_b),
        .bubble_ex(bub_b), .stall_count(cnt_b));

    fwd_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1), .ZERO_REG_EN(0)) u_dut_c (
        .clk(clk), .arst_n(arst_n), .IF_ID_Rs(IF_ID_Rs), .ID_EX_Rs(ID_EX_Rs),
        .ID_EX_Rd(ID_EX_Rd), .ID_EX_MemRead(ID_EX_MemRead), .EX_MEM_Rd(EX_MEM_Rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
        .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite), .flush(flush),
        .stat_clr(stat_clr), .fwd_sel(fwd_c), .stall_if(sif_c), .stall_id(sid_c),
        .bubble_ex(bub_c), .stall_count(cnt_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // stall outputs packed {stall_if, stall_id, bubble_ex}; all three must agree
    function automatic logic [2:0] st_a(); return {sif_a, sid_a, bub_a}; endfunction
    function automatic logic [2:0] st_b(); return {sif_b, sid_b, bub_b}; endfunction
    function automatic logic [2:0] st_c(); return {sif_c, sid_c, bub_c}; endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IF_ID_Rs        = '0;
        ID_EX_Rs        = '0;
        ID_EX_Rd        = '0;
        ID_EX_MemRead   = 1'b0;
        EX_MEM_Rd       = '0;
        EX_MEM_RegWrite = 1'b0;
        EX_MEM_MemRead  = 1'b0;
        MEM_WB_Rd       = '0;
        MEM_WB_RegWrite = 1'b0;
        flush           = 1'b0;
        stat_clr        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        tick();
    endtask

    // load-use hazard: EX load writes r9, decode reads r9 on src1
    task automatic set_hazard(input logic on);
        ID_EX_MemRead = on;
        ID_EX_Rd      = on ? 5'd9 : 5'd0;
        IF_ID_Rs      = on ? {5'd9, 5'd2} : '0;
    endtask

    initial begin
        clear_inputs();
        arst_n = 1'b0;
        #3;
        chk("rst_fwd", 32'(fwd_a), 32'h0);
        chk("rst_stall", 32'(st_a()), 32'h0);
        chk("rst_count", 32'(cnt_a), 32'h0);
        tick();
        arst_n = 1'b1;
        tick();

        // forwarding priority
        EX_MEM_Rd = 5'd5; EX_MEM_RegWrite = 1'b1;
        MEM_WB_Rd = 5'd5; MEM_WB_RegWrite = 1'b1;
        ID_EX_Rs  = {5'd5, 5'd5};
        #1 chk("fwd_exmem_prio", 32'(fwd_a), 32'b0101);
        EX_MEM_RegWrite = 1'b0;
        #1 chk("fwd_memwb", 32'(fwd_a), 32'b1010);

        // mixed sources: src1 from EX/MEM, src0 from MEM/WB
        EX_MEM_Rd = 5'd4; EX_MEM_RegWrite = 1'b1;
        MEM_WB_Rd = 5'd3; MEM_WB_RegWrite = 1'b1;
        ID_EX_Rs  = {5'd4, 5'd3};
        #1 chk("fwd_mixed", 32'(fwd_a), 32'b0110);

        // zero register
        EX_MEM_Rd = 5'd0; MEM_WB_Rd = 5'd0; ID_EX_Rs = '0;
        #1 chk("fwd_zero_en", 32'(fwd_a), 32'b0000);
        chk("fwd_zero_dis", 32'(fwd_c), 32'b0101);

        // load in MEM never forwards from EX/MEM
        tick();
        EX_MEM_Rd = 5'd7; EX_MEM_RegWrite = 1'b1; EX_MEM_MemRead = 1'b1;
        MEM_WB_Rd = 5'd0; MEM_WB_RegWrite = 1'b0;
        ID_EX_Rs  = {5'd3, 5'd7};
        #1 chk("fwd_load_mem", 32'(fwd_a), 32'b0000);
        tick();
        EX_MEM_Rd = 5'd0; EX_MEM_RegWrite = 1'b0; EX_MEM_MemRead = 1'b0;
        MEM_WB_Rd = 5'd7; MEM_WB_RegWrite = 1'b1;
        #1 chk("fwd_load_wb", 32'(fwd_a), 32'b0010);

        // zero-register load-use: only the instance without a hardwired r0 stalls
        clear_inputs();
        ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd0; IF_ID_Rs = '0;
        #1 chk("haz_r0_en", 32'(st_a()), 32'h0);
        chk("haz_r0_dis", 32'(st_c()), 32'h7);

        // load-use with LOAD_LAT=3 on instance a
        do_reset();
        set_hazard(1'b1);
        #1 chk("lu_cyc1", 32'(st_a()), 32'h7);
        tick();
        set_hazard(1'b0);
        #1 chk("lu_cyc2", 32'(st_a()), 32'h7);
        tick();
        chk("lu_cyc3", 32'(st_a()), 32'h7);
        tick();
        chk("lu_done", 32'(st_a()), 32'h0);
        chk("lu_count", 32'(cnt_a), 32'd3);
        chk("lu_lat1_count", 32'(cnt_c), 32'd1);
        tick();
        chk("lu_idle", 32'(st_a()), 32'h0);

        // flush abort with LOAD_LAT=4 on instance b
        do_reset();
        set_hazard(1'b1);
        #1 chk("fl_cyc1", 32'(st_b()), 32'h7);
        tick();
        set_hazard(1'b0);
        flush = 1'b1;
        #1 chk("fl_cyc2", 32'(st_b()), 32'h0);
        tick();
        flush = 1'b0;
        #1 chk("fl_after", 32'(st_b()), 32'h0);
        chk("fl_count", 32'(cnt_b), 32'd1);
        set_hazard(1'b1);
        flush = 1'b1;
        #1 chk("fl_idle_haz", 32'(st_b()), 32'h0);
        flush = 1'b0;
        #1 chk("fl_idle_noflush", 32'(st_b()), 32'h7);

        // reset mid-stall
        do_reset();
        set_hazard(1'b1);
        tick();
        set_hazard(1'b0);
        tick();
        chk("rs_mid_stall", 32'(st_b()), 32'h7);
        chk("rs_mid_count", 32'(cnt_b), 32'd2);
        #2;
        arst_n = 1'b0;
        EX_MEM_Rd = 5'd6; EX_MEM_RegWrite = 1'b1; ID_EX_Rs = {5'd6, 5'd6};
        #1 chk("rs_stall_forced", 32'(st_b()), 32'h0);
        chk("rs_count_clr", 32'(cnt_b), 32'h0);
        chk("rs_fwd_forced", 32'(fwd_b), 32'h0);
        tick();
        arst_n = 1'b1;
        clear_inputs();
        tick();
        chk("rs_no_replay", 32'(st_b()), 32'h0);
        tick();
        chk("rs_no_replay2", 32'(st_b()), 32'h0);
        chk("rs_count_hold", 32'(cnt_b), 32'h0);

        // saturation on instance c (stalls every cycle while the hazard is held)
        do_reset();
        set_hazard(1'b1);
        repeat (65534) tick();
        chk("sat_fffe", 32'(cnt_c), 32'hFFFE);
        repeat (3) tick();
        chk("sat_ffff", 32'(cnt_c), 32'hFFFF);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("sat_clr", 32'(cnt_c), 32'h0);
        tick();
        chk("sat_recount", 32'(cnt_c), 32'h1);
        set_hazard(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
